fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle datapath.
- Generates the PC and issues pipelined requests to a variable-latency instruction memory.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the datapath with a valid/ready handshake.
- Handles redirects (taken branch/jump) by flushing the FIFO and discarding in-flight stale responses.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and the prefetch entry type for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
    localparam logic [INST_W-1:0] NOP     = 32'h0000_0013;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] word;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO of fetch entries with push, pop and a
//               single-cycle flush. Flush overrides push and pop. Popping an
//               empty FIFO is ignored, and there is no push-to-head bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !flush;
    assign w_pop  = pop && (r_count != '0) && !flush;
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage array. Contents beyond the occupancy are never presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Upstream credit accounting must keep a push from landing on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Issues credit-limited pipelined
//               requests to a variable-latency instruction memory, buffers
//               responses in a prefetch FIFO and hands them to the datapath
//               with valid/ready. Redirects flush the FIFO and drop stale
//               in-flight responses.
//               Optional: define FETCH_PERF_EN to add saturating starvation
//               and dropped-response counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_starve_cnt,
    output logic [31:0] perf_drop_cnt,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int             CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] c_credit_lim = (CNT_W + 1)'(DEPTH);

    logic              r_run;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_outstanding_nxt;
    logic [ADDR_W-1:0] w_redirect_target;
    logic              w_req_fire;
    logic              w_resp_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_unused          = &{1'b0, redirect_pc[1:0]};

    // Buffered plus in-flight words may never exceed the FIFO size, so every
    // response that is not dropped is guaranteed a slot.
    assign imem_req_valid = r_run && !redirect_valid &&
                            (({1'b0, w_count} + {1'b0, r_outstanding}) < c_credit_lim);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses in the redirect cycle belong to the old stream.
    assign w_resp_drop  = imem_resp_valid && (redirect_valid || (r_drop_cnt != '0));
    assign w_push       = imem_resp_valid && !w_resp_drop;
    assign w_push_entry = '{pc: r_resp_pc, word: imem_resp_data};

    assign inst_valid = (w_count != '0);
    assign inst_word  = inst_valid ? w_head.word : '0;
    assign inst_pc    = inst_valid ? w_head.pc   : '0;
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;

    assign w_outstanding_nxt = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_resp_valid);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .count     (w_count),
        .head      (w_head)
    );

    // PC generation, outstanding-request credit and stale-response drop count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                r_fetch_pc <= w_redirect_target;
                r_resp_pc  <= w_redirect_target;
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PC_STEP;
                end
                if (w_resp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_starve;
    logic [31:0] r_perf_drop;

    assign perf_starve_cnt = r_perf_starve;
    assign perf_drop_cnt   = r_perf_drop;

    // Saturating counts of starved cycles and discarded responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_starve <= '0;
            r_perf_drop   <= '0;
        end else begin
            if (!inst_valid && (r_perf_starve != '1)) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
            if (w_resp_drop && (r_perf_drop != '1)) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a simple
//               in-order, fixed-latency instruction memory model. Memory
//               returns (salt | address) so every word identifies its PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk             = 1'b0;
    logic        reset           = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready  = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        inst_valid;
    logic        inst_ready      = 1'b0;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic        redirect_valid  = 1'b0;
    logic [31:0] redirect_pc     = 32'h0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_starve_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int          n_total = 0;
    int          n_bad   = 0;
    int          lat     = 1;
    int          mcyc    = 0;
    logic [31:0] salt    = 32'hA000_0000;
    logic [31:0] q_addr[$];
    int          q_due[$];

    int          nreq;
    int          found;
    int          stale;
    logic [31:0] last_addr;
    logic [31:0] first_pc;
    logic [31:0] first_word;

    fetch_unit u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_word       (inst_word),
        .inst_pc         (inst_pc),
`ifdef FETCH_PERF_EN
        .perf_starve_cnt (perf_starve_cnt),
        .perf_drop_cnt   (perf_drop_cnt),
`endif
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Step to one time unit after the next falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Hold reset long enough for any in-flight response to drain, then
    // release; returns at the first cycle the request may be visible.
    task automatic do_reset();
        reset = 1'b0;
        tick(8);
        reset = 1'b1;
        tick();
    endtask

    // Memory model: decides the response for the next rising edge and
    // captures any request that edge will accept.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            mcyc++;
            if (q_addr.size() > 0 && q_due[0] <= mcyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = salt | q_addr[0];
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(mcyc + lat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1;
        check("rst_req_valid",  32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid),     32'd0);
        check("rst_inst_word",  inst_word,           32'd0);
        check("rst_inst_pc",    inst_pc,             32'd0);

        // Streaming, 1-cycle latency
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        check("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_addr0",     imem_req_addr,       32'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t1_addr", imem_req_addr, 32'(4 * k));
            if (k >= 2) begin
                check("t1_inst_valid", 32'(inst_valid), 32'd1);
                check("t1_inst_pc",    inst_pc,         32'(4 * (k - 2)));
                check("t1_inst_word",  inst_word,       32'hA000_0000 | 32'(4 * (k - 2)));
            end
        end

        // Datapath stalled: credit caps requests at DEPTH
        inst_ready = 1'b0;
        do_reset();
        nreq = 0; last_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (imem_req_valid && imem_req_ready) begin
                nreq++;
                last_addr = imem_req_addr;
            end
        end
        check("t2_nreq",      32'(nreq),           32'd4);
        check("t2_last_addr", last_addr,           32'd12);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_head_pc",   inst_pc,             32'd0);
        inst_ready = 1'b1;
        tick();
        check("t2_drain_pc4",  inst_pc,             32'd4);
        check("t2_resume_vld", 32'(imem_req_valid), 32'd1);
        check("t2_resume_adr", imem_req_addr,       32'd16);
        tick();
        check("t2_drain_pc8",  inst_pc, 32'd8);
        tick();
        check("t2_drain_pc12", inst_pc, 32'd12);
        tick();
        check("t2_drain_pc16", inst_pc, 32'd16);

        // Memory not ready: request holds
        imem_req_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check("t3_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t3_hold_addr",  imem_req_addr,       32'd0);
        end
        imem_req_ready = 1'b1;
        tick();
        check("t3_next_addr", imem_req_addr, 32'd4);

        // Redirect with three requests in flight (latency 5)
        lat = 5;
        do_reset();
        tick(3);
        check("t4_pre_addr", imem_req_addr, 32'd12);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        #1;
        check("t4_req_suppr", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr",  imem_req_addr,       32'h100);
        found = 0; stale = 0; first_pc = 32'h0; first_word = 32'h0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (inst_valid) begin
                if (found == 0) begin
                    first_pc   = inst_pc;
                    first_word = inst_word;
                    found      = 1;
                end
                if (inst_pc < 32'h100) stale++;
            end
        end
        check("t4_found",      32'(found), 32'd1);
        check("t4_first_pc",   first_pc,   32'h100);
        check("t4_first_word", first_word, 32'hA000_0100);
        check("t4_stale",      32'(stale), 32'd0);

        // Redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        tick(3);
        check("t5_pre_valid", 32'(inst_valid), 32'd1);
        check("t5_pre_pc",    inst_pc,         32'd4);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        #1;
        check("t5_req_suppr", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_inst_valid", 32'(inst_valid),     32'd0);
        check("t5_inst_pc",    inst_pc,             32'd0);
        check("t5_req_valid",  32'(imem_req_valid), 32'd1);
        check("t5_req_addr",   imem_req_addr,       32'h200);
        tick();
        check("t5_gap_valid", 32'(inst_valid), 32'd0);
        tick();
        check("t5_new_valid", 32'(inst_valid), 32'd1);
        check("t5_new_pc",    inst_pc,         32'h200);
        check("t5_new_word",  inst_word,       32'hA000_0200);

        // Reset mid-operation: 2 buffered, 2 outstanding
        lat = 3; inst_ready = 1'b0;
        do_reset();
        tick(5);
        check("t6_pre_valid", 32'(inst_valid),     32'd1);
        check("t6_pre_pc",    inst_pc,             32'd0);
        check("t6_pre_req",   32'(imem_req_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_rst_req_valid",  32'(imem_req_valid), 32'd0);
        check("t6_rst_req_addr",   imem_req_addr,       32'd0);
        check("t6_rst_inst_valid", 32'(inst_valid),     32'd0);
        check("t6_rst_inst_word",  inst_word,           32'd0);
        check("t6_rst_inst_pc",    inst_pc,             32'd0);
        tick(8);
        salt = 32'hB000_0000; lat = 1; inst_ready = 1'b1;
        reset = 1'b1;
        tick();
        check("t6_post_valid", 32'(imem_req_valid), 32'd1);
        check("t6_post_addr",  imem_req_addr,       32'd0);
        tick(2);
        check("t6_post_ivalid", 32'(inst_valid), 32'd1);
        check("t6_post_pc",     inst_pc,         32'd0);
        check("t6_post_word",   inst_word,       32'hB000_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
